// File: rtl/lamp_fpu_i2f_pipe.sv
// Three-stage integer-to-float converter for the lampFPU datapath.
// Produces sign, biased exponent and an unrounded {0,hidden,frac,G,R,S} fraction under valid/ready.
module lamp_fpu_i2f_pipe #(
    parameter int INT_DW = 32,
    parameter int E_DW   = 8,
    parameter int F_DW   = 7,
    parameter int E_BIAS = 127,
    parameter int TAG_DW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [INT_DW-1:0] op_i,
    input  logic              isSigned_i,
    input  logic [TAG_DW-1:0] tag_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              s_res_o,
    output logic [E_DW-1:0]   e_res_o,
    output logic [F_DW+4:0]   f_res_o,
    output logic [TAG_DW-1:0] tag_o,
    output logic              isToRound_o,
    output logic              isInexact_o,
    output logic              isOverflow_o
);

    localparam int PW = (INT_DW > 1) ? $clog2(INT_DW) : 1;
    localparam int MW = F_DW + 3;
    localparam logic [PW-1:0]     PMAX = PW'(INT_DW - 1);
    localparam logic [INT_DW-1:0] ONE  = {{(INT_DW-1){1'b0}}, 1'b1};
    localparam logic [31:0]       EMAX = (32'd1 << E_DW) - 32'd1;

    function automatic logic [PW-1:0] msb_pos(input logic [INT_DW-1:0] v);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < INT_DW; i++) begin
            if (v[i]) p = PW'(i);
            else      p = p;
        end
        return p;
    endfunction

    logic              stall_s;
    logic              sign_s;
    logic [INT_DW-1:0] mag_s;
    logic [PW-1:0]     sh_s;
    logic [INT_DW+F_DW+1:0] norm_s;
    logic [31:0]       exp_full_s;
    logic              ovf_s;

    logic              s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, out_vld_q, out_vld_d;
    logic              s1_sign_q, s1_sign_d, s1_zero_q, s1_zero_d;
    logic [INT_DW-1:0] s1_mag_q, s1_mag_d;
    logic [PW-1:0]     s1_pos_q, s1_pos_d;
    logic [TAG_DW-1:0] s1_tag_q, s1_tag_d;
    logic              s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d, s2_stk_q, s2_stk_d;
    logic [PW-1:0]     s2_pos_q, s2_pos_d;
    logic [MW-1:0]     s2_mant_q, s2_mant_d;
    logic [TAG_DW-1:0] s2_tag_q, s2_tag_d;
    logic              s_res_q, s_res_d, to_round_q, to_round_d;
    logic              inexact_q, inexact_d, ovf_q, ovf_d;
    logic [E_DW-1:0]   e_res_q, e_res_d;
    logic [F_DW+4:0]   f_res_q, f_res_d;
    logic [TAG_DW-1:0] tag_q, tag_d;

    assign stall_s = out_vld_q & ~ready_i;
    assign ready_o = ~stall_s;

    // Stage valids: flush wins over stall, stall freezes the whole pipe.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s2_vld_d  = s2_vld_q;
        out_vld_d = out_vld_q;
        if (flush_i) begin
            s1_vld_d  = 1'b0;
            s2_vld_d  = 1'b0;
            out_vld_d = 1'b0;
        end else if (!stall_s) begin
            s1_vld_d  = valid_i;
            s2_vld_d  = s1_vld_q;
            out_vld_d = s2_vld_q;
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // Stage 1: sign, magnitude and leading-one position.
    always_comb begin
        sign_s = isSigned_i & op_i[INT_DW-1];
        if (sign_s) mag_s = ~op_i + ONE;
        else        mag_s = op_i;
        s1_sign_d = s1_sign_q;
        s1_mag_d  = s1_mag_q;
        s1_pos_d  = s1_pos_q;
        s1_zero_d = s1_zero_q;
        s1_tag_d  = s1_tag_q;
        if (!stall_s) begin
            s1_sign_d = sign_s;
            s1_mag_d  = mag_s;
            s1_pos_d  = msb_pos(mag_s);
            s1_zero_d = ~|mag_s;
            s1_tag_d  = tag_i;
        end else begin
            s1_tag_d  = s1_tag_q;
        end
    end

    // Stage 2: shift leading one to the top; everything below R collapses into sticky.
    always_comb begin
        sh_s      = PMAX - s1_pos_q;
        norm_s    = {s1_mag_q, {(F_DW+2){1'b0}}} << sh_s;
        s2_sign_d = s2_sign_q;
        s2_zero_d = s2_zero_q;
        s2_pos_d  = s2_pos_q;
        s2_mant_d = s2_mant_q;
        s2_stk_d  = s2_stk_q;
        s2_tag_d  = s2_tag_q;
        if (!stall_s) begin
            s2_sign_d = s1_sign_q;
            s2_zero_d = s1_zero_q;
            s2_pos_d  = s1_pos_q;
            s2_mant_d = norm_s[INT_DW+F_DW+1 -: MW];
            s2_stk_d  = |norm_s[INT_DW-2:0];
            s2_tag_d  = s1_tag_q;
        end else begin
            s2_tag_d  = s2_tag_q;
        end
    end

    // Stage 3: bias the exponent and classify zero / overflow / normal.
    always_comb begin
        exp_full_s = {{(32-PW){1'b0}}, s2_pos_q} + 32'(E_BIAS);
        ovf_s      = (exp_full_s >= EMAX);
        s_res_d    = s_res_q;
        e_res_d    = e_res_q;
        f_res_d    = f_res_q;
        tag_d      = tag_q;
        to_round_d = to_round_q;
        inexact_d  = inexact_q;
        ovf_d      = ovf_q;
        if (!stall_s) begin
            tag_d = s2_tag_q;
            if (s2_zero_q) begin
                s_res_d    = 1'b0;
                e_res_d    = '0;
                f_res_d    = '0;
                to_round_d = 1'b0;
                inexact_d  = 1'b0;
                ovf_d      = 1'b0;
            end else if (ovf_s) begin
                s_res_d    = s2_sign_q;
                e_res_d    = '1;
                f_res_d    = '0;
                to_round_d = 1'b0;
                inexact_d  = 1'b0;
                ovf_d      = 1'b1;
            end else begin
                s_res_d    = s2_sign_q;
                e_res_d    = exp_full_s[E_DW-1:0];
                f_res_d    = {1'b0, s2_mant_q, s2_stk_q};
                to_round_d = 1'b1;
                inexact_d  = |{s2_mant_q[1:0], s2_stk_q};
                ovf_d      = 1'b0;
            end
        end else begin
            tag_d = tag_q;
        end
    end

    // Valid and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            s_res_q    <= 1'b0;
            e_res_q    <= '0;
            f_res_q    <= '0;
            tag_q      <= '0;
            to_round_q <= 1'b0;
            inexact_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            out_vld_q  <= out_vld_d;
            s_res_q    <= s_res_d;
            e_res_q    <= e_res_d;
            f_res_q    <= f_res_d;
            tag_q      <= tag_d;
            to_round_q <= to_round_d;
            inexact_q  <= inexact_d;
            ovf_q      <= ovf_d;
        end
    end

    // Internal stage data; qualified by the valids so no reset is needed.
    always_ff @(posedge clk) begin
        s1_sign_q <= s1_sign_d;
        s1_mag_q  <= s1_mag_d;
        s1_pos_q  <= s1_pos_d;
        s1_zero_q <= s1_zero_d;
        s1_tag_q  <= s1_tag_d;
        s2_sign_q <= s2_sign_d;
        s2_zero_q <= s2_zero_d;
        s2_pos_q  <= s2_pos_d;
        s2_mant_q <= s2_mant_d;
        s2_stk_q  <= s2_stk_d;
        s2_tag_q  <= s2_tag_d;
    end

    assign valid_o      = out_vld_q;
    assign s_res_o      = s_res_q;
    assign e_res_o      = e_res_q;
    assign f_res_o      = f_res_q;
    assign tag_o        = tag_q;
    assign isToRound_o  = to_round_q;
    assign isInexact_o  = inexact_q;
    assign isOverflow_o = ovf_q;

endmodule

// File: tb/tb_lamp_fpu_i2f_pipe.sv
// Directed bench for lamp_fpu_i2f_pipe: conversions, overflow (narrow exponent), backpressure, flush, reset.
module tb_lamp_fpu_i2f_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        isSigned_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [31:0] op_i = 32'd0;
    logic [3:0]  tag_i = 4'd0;

    logic        ready_o, valid_o, s_res_o, isToRound_o, isInexact_o, isOverflow_o;
    logic [7:0]  e_res_o;
    logic [11:0] f_res_o;
    logic [3:0]  tag_o;

    logic        ready5, valid5, s5, tr5, inx5, ovf5;
    logic [4:0]  e5;
    logic [11:0] f5;
    logic [3:0]  tag5;

    int total = 0;
    int bad   = 0;

    lamp_fpu_i2f_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .isSigned_i(isSigned_i), .tag_i(tag_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .s_res_o(s_res_o), .e_res_o(e_res_o), .f_res_o(f_res_o),
        .tag_o(tag_o), .isToRound_o(isToRound_o), .isInexact_o(isInexact_o),
        .isOverflow_o(isOverflow_o)
    );

    lamp_fpu_i2f_pipe #(.E_DW(5), .E_BIAS(15)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready5), .op_i(op_i),
        .isSigned_i(isSigned_i), .tag_i(tag_i), .flush_i(flush_i), .valid_o(valid5),
        .ready_i(ready_i), .s_res_o(s5), .e_res_o(e5), .f_res_o(f5),
        .tag_o(tag5), .isToRound_o(tr5), .isInexact_o(inx5), .isOverflow_o(ovf5)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // directed vectors: op, signed, s, e, f, toRound, inexact
    logic [31:0] v_op  [12] = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'd200,
                                32'd301, 32'd1023, 32'd1025, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h7FFFFFFF};
    logic        v_sgn [12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        v_s   [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0]  v_e   [12] = '{8'd127, 8'd127, 8'd158, 8'd158, 8'd0, 8'd134, 8'd135, 8'd136,
                                8'd137, 8'd128, 8'd157, 8'd157};
    logic [11:0] v_f   [12] = '{12'h400, 12'h400, 12'h7FF, 12'h400, 12'h000, 12'h640, 12'h4B4,
                                12'h7FE, 12'h401, 12'h400, 12'h7FF, 12'h7FF};
    logic        v_tr  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        v_inx [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // stream vectors (unsigned)
    logic [31:0] s_op [6] = '{32'd1, 32'd200, 32'd301, 32'd1023, 32'd1025, 32'hFFFFFFFF};
    logic [7:0]  s_e  [6] = '{8'd127, 8'd134, 8'd135, 8'd136, 8'd137, 8'd158};
    logic [11:0] s_f  [6] = '{12'h400, 12'h640, 12'h4B4, 12'h7FE, 12'h401, 12'h7FF};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] op, input logic sgn, input logic [3:0] tg);
        valid_i    = 1'b1;
        op_i       = op;
        isSigned_i = sgn;
        tag_i      = tg;
        @(posedge clk); #1;
        valid_i    = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (valid_o !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("out_seen", 32'(valid_o), 32'd1);
    endtask

    task automatic check_res(input string nm, input logic s, input logic [7:0] e, input logic [11:0] f,
                             input logic tr, input logic inx, input logic [3:0] tg);
        check_eq({nm, "_s"},   32'(s_res_o),      32'(s));
        check_eq({nm, "_e"},   32'(e_res_o),      32'(e));
        check_eq({nm, "_f"},   32'(f_res_o),      32'(f));
        check_eq({nm, "_tr"},  32'(isToRound_o),  32'(tr));
        check_eq({nm, "_inx"}, 32'(isInexact_o),  32'(inx));
        check_eq({nm, "_ovf"}, 32'(isOverflow_o), 32'd0);
        check_eq({nm, "_tag"}, 32'(tag_o),        32'(tg));
    endtask

    int          lat;
    int          idx, nrx, seen;
    logic        fire, hold_v;
    logic [11:0] hold_f;
    logic [7:0]  hold_e;
    logic [3:0]  hold_t;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_ready", 32'(ready_o), 32'd1);
        check_eq("rst_e",     32'(e_res_o), 32'd0);
        check_eq("rst_ready5", 32'(ready5), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            issue(v_op[i], v_sgn[i], 4'(i));
            wait_out(lat);
            if (i == 0) check_eq("latency", 32'(lat), 32'd2);
            check_res($sformatf("vec%0d", i), v_s[i], v_e[i], v_f[i], v_tr[i], v_inx[i], 4'(i));
        end

        // narrow exponent: p=16 overflows E_DW=5, p=15 fits
        issue(32'h00010000, 1'b0, 4'hA);
        wait_out(lat);
        check_eq("ovf5_valid", 32'(valid5), 32'd1);
        check_eq("ovf5_flag",  32'(ovf5),   32'd1);
        check_eq("ovf5_e",     32'(e5),     32'h1F);
        check_eq("ovf5_f",     32'(f5),     32'd0);
        check_eq("ovf5_tr",    32'(tr5),    32'd0);
        check_eq("ovf5_tag",   32'(tag5),   32'hA);
        check_eq("wide_e",     32'(e_res_o), 32'd143);
        issue(32'h00008000, 1'b0, 4'hB);
        wait_out(lat);
        check_eq("fit5_flag", 32'(ovf5), 32'd0);
        check_eq("fit5_e",    32'(e5),   32'd30);
        check_eq("fit5_f",    32'(f5),   32'h400);
        check_eq("fit5_s",    32'(s5),   32'd0);
        check_eq("fit5_inx",  32'(inx5), 32'd0);
        @(posedge clk); #1;

        // stream with a 5-cycle downstream stall
        idx = 0; nrx = 0; hold_v = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            valid_i    = (idx < 6);
            op_i       = (idx < 6) ? s_op[idx] : 32'd0;
            tag_i      = 4'(idx);
            isSigned_i = 1'b0;
            ready_i    = !(cyc >= 4 && cyc < 9);
            @(negedge clk);
            if (hold_v) begin
                check_eq("hold_valid", 32'(valid_o), 32'd1);
                check_eq("hold_f",     32'(f_res_o), 32'(hold_f));
                check_eq("hold_e",     32'(e_res_o), 32'(hold_e));
                check_eq("hold_tag",   32'(tag_o),   32'(hold_t));
            end
            hold_v = valid_o && !ready_i;
            if (hold_v) begin
                check_eq("stall_ready", 32'(ready_o), 32'd0);
                hold_f = f_res_o;
                hold_e = e_res_o;
                hold_t = tag_o;
            end
            if (valid_o && ready_i) begin
                if (nrx < 6) begin
                    check_eq($sformatf("strm%0d_tag", nrx), 32'(tag_o),   32'(nrx));
                    check_eq($sformatf("strm%0d_e", nrx),   32'(e_res_o), 32'(s_e[nrx]));
                    check_eq($sformatf("strm%0d_f", nrx),   32'(f_res_o), 32'(s_f[nrx]));
                end else begin
                    check_eq("strm_extra", 32'(valid_o), 32'd0);
                end
                nrx++;
            end
            fire = valid_i && ready_o;
            @(posedge clk); #1;
            if (fire) idx++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        check_eq("strm_count", 32'(nrx), 32'd6);

        // flush with ops in flight and one on the input
        valid_i = 1'b1; op_i = 32'd200; tag_i = 4'd1;
        @(posedge clk); #1;
        op_i = 32'd301; tag_i = 4'd2;
        @(posedge clk); #1;
        op_i = 32'd1023; tag_i = 4'd3; flush_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        check_eq("flush_ready", 32'(ready_o), 32'd1);
        seen = 0;
        repeat (6) begin
            if (valid_o) seen++;
            @(posedge clk); #1;
        end
        check_eq("flush_none", 32'(seen), 32'd0);
        issue(32'd301, 1'b0, 4'h9);
        wait_out(lat);
        check_res("post_flush", 1'b0, 8'd135, 12'h4B4, 1'b1, 1'b1, 4'h9);
        @(posedge clk); #1;

        // asynchronous reset mid-stream
        issue(32'd1025, 1'b0, 4'h4);
        issue(32'd200, 1'b0, 4'h5);
        rst_n = 1'b0;
        #2;
        check_eq("arst_valid", 32'(valid_o), 32'd0);
        check_eq("arst_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        repeat (6) begin
            if (valid_o) seen++;
            @(posedge clk); #1;
        end
        check_eq("arst_none", 32'(seen), 32'd0);
        issue(32'hFFFFFFFE, 1'b1, 4'h7);
        wait_out(lat);
        check_res("post_rst", 1'b1, 8'd128, 12'h400, 1'b1, 1'b0, 4'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
